dmem_dump_ctrl: RTL and testbench

Data-memory port controller for the single-cycle microarchitecture. It sits between the CPU load/store path and the data memory `DM` and shares the single memory port between two requesters. The CPU has priority. A dump sequencer steals idle cycles to read a word-address window in order and stream each word out over a valid/ready interface. This gives in-system memory dumps, for example to the GPIO or a debug link, without a testbench backdoor.

---
 rtl/micro_pkg.sv | 36 +++
 rtl/dmem_dump_ctrl_if.sv | 38 +++
 rtl/dmem_dump_ctrl_port_mux.sv | 30 +++
 rtl/dmem_dump_ctrl.sv | 134 +++++++++++++
 tb/tb_dmem_dump_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the data-memory dump controller.
// Holds the dump FSM state encoding, the word size, the default dump window
// and two width helpers used to size the index register and the wait counter.
package micro_pkg;

  typedef enum logic [1:0] {
    DD_IDLE  = 2'd0,
    DD_FETCH = 2'd1,
    DD_HOLD  = 2'd2,
    DD_DONE  = 2'd3
  } dd_state_t;

  localparam int WORD_BYTES  = 4;
  localparam int DMEM_IDX_LO = -64;
  localparam int DMEM_IDX_HI = 64;

  // Smallest two's-complement width that holds every value in lo..hi.
  function automatic int idx_width(input int lo, input int hi);
    int span;
    int w;
    span = (-lo > hi + 1) ? -lo : hi + 1;
    if (span < 1) span = 1;
    w = 1;
    while ((1 << (w - 1)) < span) w++;
    return w;
  endfunction

  // Smallest unsigned width that holds 0..max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/dmem_dump_ctrl_if.sv
// Bundle of every non-clock signal of the dump controller.
//   start/abort/busy/done       : dump control
//   cpu_*                       : CPU load/store side of the shared port
//   mem_*                       : data memory side (mem_rdata is combinational)
//   dump_valid/ready/addr/data  : dump word stream
// slave  = controller view, master = environment (CPU, memory, sink) view.
interface dmem_dump_ctrl_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;

  modport slave (
    input  start, abort, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, dump_ready,
    output busy, done, cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata,
           dump_valid, dump_addr, dump_data
  );

  modport master (
    output start, abort, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, dump_ready,
    input  busy, done, cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata,
           dump_valid, dump_addr, dump_data
  );
endinterface

// File: rtl/dmem_dump_ctrl_port_mux.sv
// Combinational select of the single data-memory port between the CPU and
// the dump engine.
//   gnt_d           : dump engine owns the port this cycle (read only)
//   dump_fetch_addr : byte address the dump engine reads
//   cpu_req/we/addr/wdata : CPU access
//   mem_we/addr/wdata     : memory port
module dmem_port_mux (
  input  logic        gnt_d,
  input  logic [31:0] dump_fetch_addr,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata
);

  always_comb begin
    mem_we    = 4'h0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (gnt_d) begin
      mem_addr = dump_fetch_addr;
    end else if (cpu_req) begin
      mem_we = cpu_we;
    end
  end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Data-memory port controller: shares the memory port between the CPU
// (priority) and a dump sequencer that reads word indices IDX_LO..IDX_HI in
// order and streams each word out on a valid/ready interface.
//   clk, reset : clock, synchronous active-high reset
//   bus        : control, CPU, memory and dump stream signals (slave view)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DD_IDLE  | waiting for start
// DD_FETCH | waiting for a free (or forced) memory cycle to read word idx
// DD_HOLD  | word presented on the dump stream until accepted
// DD_DONE  | one-cycle done pulse after the last word
module dmem_dump_ctrl
  import micro_pkg::*;
#(
  parameter int IDX_LO     = DMEM_IDX_LO,
  parameter int IDX_HI     = DMEM_IDX_HI,
  parameter int STARVE_MAX = 8
) (
  input logic             clk,
  input logic             reset,
  dmem_dump_ctrl_if.slave bus
);

  localparam int IW       = idx_width(IDX_LO, IDX_HI);
  localparam int CW       = cnt_width(STARVE_MAX);
  localparam int ADDR_LSB = $clog2(WORD_BYTES);

  localparam logic signed [IW-1:0] IDX_FIRST  = IW'(IDX_LO);
  localparam logic signed [IW-1:0] IDX_LAST   = IW'(IDX_HI);
  localparam logic [CW-1:0]        WAIT_LIMIT = CW'(STARVE_MAX);

  dd_state_t state, state_nxt;

  logic signed [IW-1:0]          idx;
  logic [CW-1:0]                 wait_cnt;
  logic [31:0]                   dump_data_q;
  logic [31:0]                   dump_addr_q;
  logic                          gnt_d;
  logic                          hs;
  logic signed [IW+ADDR_LSB-1:0] idx_byte;
  logic [31:0]                   dump_fetch_addr;
  logic [3:0]                    mem_we_int;
  logic [31:0]                   mem_addr_int;
  logic [31:0]                   mem_wdata_int;

  // Signed word index to sign-extended byte address.
  assign idx_byte        = {idx, {ADDR_LSB{1'b0}}};
  assign dump_fetch_addr = 32'(idx_byte);

  always_ff @(posedge clk) begin
    if (reset) state <= DD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = DD_IDLE;
    end else begin
      case (state)
        DD_IDLE:  if (bus.start) state_nxt = DD_FETCH;
        DD_FETCH: if (gnt_d) state_nxt = DD_HOLD;
        DD_HOLD:  if (hs) state_nxt = (idx == IDX_LAST) ? DD_DONE : DD_FETCH;
        DD_DONE:  state_nxt = DD_IDLE;
        default:  state_nxt = DD_IDLE;
      endcase
    end
  end

  // A stall is forced only once the CPU has denied the engine STARVE_MAX
  // cycles in a row; the grant then clears wait_cnt, and HOLD lasts at least
  // one cycle, so two stalls can never be adjacent.
  always_comb begin
    bus.busy       = (state == DD_FETCH) || (state == DD_HOLD);
    bus.done       = (state == DD_DONE);
    bus.dump_valid = (state == DD_HOLD);
    bus.cpu_stall  = (state == DD_FETCH) && bus.cpu_req && (wait_cnt == WAIT_LIMIT);
    gnt_d          = (state == DD_FETCH) && (!bus.cpu_req || bus.cpu_stall);
    hs             = (state == DD_HOLD) && bus.dump_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      wait_cnt    <= '0;
      dump_data_q <= '0;
      dump_addr_q <= '0;
    end else if (!bus.abort) begin
      case (state)
        DD_IDLE: begin
          if (bus.start) begin
            idx      <= IDX_FIRST;
            wait_cnt <= '0;
          end
        end
        DD_FETCH: begin
          if (gnt_d) begin
            // Snapshot at the grant; later CPU stores do not reach the held word.
            dump_data_q <= bus.mem_rdata;
            dump_addr_q <= mem_addr_int;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DD_HOLD: begin
          if (hs && (idx != IDX_LAST)) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  dmem_port_mux u_port_mux (
    .gnt_d           (gnt_d),
    .dump_fetch_addr (dump_fetch_addr),
    .cpu_req         (bus.cpu_req),
    .cpu_we          (bus.cpu_we),
    .cpu_addr        (bus.cpu_addr),
    .cpu_wdata       (bus.cpu_wdata),
    .mem_we          (mem_we_int),
    .mem_addr        (mem_addr_int),
    .mem_wdata       (mem_wdata_int)
  );

  assign bus.mem_we    = mem_we_int;
  assign bus.mem_addr  = mem_addr_int;
  assign bus.mem_wdata = mem_wdata_int;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dump_data = dump_data_q;
  assign bus.dump_addr = dump_addr_q;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Directed bench for dmem_dump_ctrl with a 256-word behavioural memory.
module tb_dmem_dump_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic preload_req;
  logic [31:0] mem [0:255];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_dump_ctrl_if bus ();

  dmem_dump_ctrl #(
    .IDX_LO     (-64),
    .IDX_HI     (64),
    .STARVE_MAX (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word slot j holds 0xA5000000 + signed index (slots 128..255 are negative).
  always @(posedge clk) begin
    if (preload_req) begin
      for (int j = 0; j < 256; j++)
        mem[j] <= 32'hA500_0000 + 32'((j < 128) ? j : j - 256);
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    preload_req = 1'b1;
    to_next();
    preload_req = 1'b0;
  endtask

  // Runs one dump from IDLE; cycle 1 is the start cycle.
  task automatic run_dump(input string name, input bit cpu_on, input int slow_idx,
                          input int slow_cyc, input bit start_again, input int exp_done);
    int exp_i, low_left, words, done_cyc, stalls, fetch_run;
    bit prev_valid, prev_stall, storing;
    logic [31:0] held_a, held_d;
    exp_i = -64; low_left = slow_cyc; words = 0; done_cyc = 0; stalls = 0;
    fetch_run = 0; prev_valid = 0; prev_stall = 0; held_a = '0; held_d = '0;
    for (int cyc = 1; cyc <= 3000 && done_cyc == 0; cyc++) begin
      bus.start      = (cyc == 1) || (start_again && cyc >= 40 && cyc <= 42);
      bus.cpu_req    = cpu_on;
      bus.cpu_we     = cpu_on ? 4'hF : 4'h0;
      bus.cpu_addr   = 32'h190;
      bus.cpu_wdata  = 32'hCAFE_F00D;
      bus.dump_ready = 1'b1;
      storing = 0;
      if (bus.dump_valid && bus.dump_addr == 32'(slow_idx * 4) && low_left > 0) begin
        low_left--;
        storing        = 1;
        bus.dump_ready = 1'b0;
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 4'hF;
        bus.cpu_addr   = 32'(slow_idx * 4);
        bus.cpu_wdata  = 32'h1234_5678;
      end
      @(negedge clk);
      if (storing) begin
        chk({name, " store mem_we"}, 32'(bus.mem_we), 32'hF);
        chk({name, " store mem_addr"}, bus.mem_addr, 32'(slow_idx * 4));
        chk({name, " store mem_wdata"}, bus.mem_wdata, 32'h1234_5678);
      end
      if (bus.busy && !bus.dump_valid) fetch_run++;
      if (bus.cpu_stall) begin
        stalls++;
        chk({name, " stall mem_we"}, 32'(bus.mem_we), 32'h0);
        chk({name, " stall spacing"}, 32'(fetch_run), 32'd9);
        chk({name, " stall back-to-back"}, 32'(prev_stall), 32'd0);
      end else if (cpu_on && bus.busy && !bus.dump_valid) begin
        chk({name, " cpu passthrough we"}, 32'(bus.mem_we), 32'hF);
      end
      if (bus.dump_valid) begin
        fetch_run = 0;
        if (prev_valid) begin
          chk({name, " hold addr stable"}, bus.dump_addr, held_a);
          chk({name, " hold data stable"}, bus.dump_data, held_d);
        end
        held_a = bus.dump_addr;
        held_d = bus.dump_data;
        if (bus.dump_ready) begin
          chk({name, " word addr"}, bus.dump_addr, 32'(exp_i * 4));
          chk({name, " word data"}, bus.dump_data, 32'hA500_0000 + 32'(exp_i));
          exp_i++;
          words++;
        end
      end
      prev_valid = bus.dump_valid && !bus.dump_ready;
      prev_stall = bus.cpu_stall;
      if (bus.done) done_cyc = cyc;
      to_next();
    end
    bus.start = 0; bus.cpu_req = 0; bus.cpu_we = 0; bus.dump_ready = 0;
    chk({name, " word count"}, 32'(words), 32'd129);
    chk({name, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({name, " stall count"}, 32'(stalls), cpu_on ? 32'd129 : 32'd0);
  endtask

  initial begin
    bit found;
    reset = 1'b1; preload_req = 1'b0;
    bus.start = 0; bus.abort = 0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.dump_ready = 0;
    preload();
    to_next();
    reset = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst dump_valid", 32'(bus.dump_valid), 32'd0);
    chk("rst cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst dump_data", bus.dump_data, 32'd0);
    chk("rst dump_addr", bus.dump_addr, 32'd0);
    to_next();

    bus.cpu_req = 1; bus.cpu_addr = 32'h8;
    @(negedge clk);
    chk("idle mem_addr", bus.mem_addr, 32'h8);
    chk("idle cpu_rdata", bus.cpu_rdata, 32'hA500_0002);
    to_next();
    bus.cpu_req = 0;

    run_dump("idle-cpu", 1'b0, -999, 0, 1'b0, 260);
    run_dump("start-while-busy", 1'b0, -999, 0, 1'b1, 260);

    preload();
    run_dump("cpu-starve", 1'b1, -999, 0, 1'b0, 1292);

    preload();
    run_dump("slow-sink", 1'b0, 0, 5, 1'b0, 265);
    chk("slow-sink store in mem", mem[0], 32'h1234_5678);

    preload();
    found = 0;
    bus.start = 1; bus.dump_ready = 1;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus.dump_valid && bus.dump_addr == 32'd40) found = 1;
      else begin
        to_next();
        bus.start = 0;
      end
    end
    chk("abort reached idx 10", 32'(found), 32'd1);
    bus.abort = 1;
    to_next();
    bus.abort = 0; bus.dump_ready = 0;
    @(negedge clk);
    chk("abort dump_valid", 32'(bus.dump_valid), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    for (int c = 0; c < 4; c++) begin
      to_next();
      @(negedge clk);
      chk("abort no done", 32'(bus.done), 32'd0);
    end
    to_next();
    run_dump("after-abort", 1'b0, -999, 0, 1'b0, 260);

    found = 0;
    bus.start = 1; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h8;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (bus.cpu_stall) found = 1;
      else begin
        to_next();
        bus.start = 0;
      end
    end
    chk("reset reached stall", 32'(found), 32'd1);
    reset = 1'b1;
    to_next();
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset dump_valid", 32'(bus.dump_valid), 32'd0);
    chk("reset cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("reset mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset dump_data", bus.dump_data, 32'd0);
    chk("reset dump_addr", bus.dump_addr, 32'd0);
    bus.cpu_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
